// File: rtl/strobe_interval_meter.sv
`default_nettype none
// ============================================================================
// Module   : strobe_interval_meter
// Brief    : Counts enable ticks between consecutive strobes using a chunked,
//            carry-pipelined counter. Each interval is resolved through a
//            LATENCY-deep pipeline and presented on a valid/ready output.
// Revision : 1.0 - initial release
// ============================================================================
module strobe_interval_meter #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             strobe,
    output logic             armed,
    output logic [WIDTH-1:0] measure_value,
    output logic             measure_overflow,
    output logic             measure_valid,
    input  logic             measure_ready,
    output logic             overrun
);

    // Chunk geometry: LATENCY chunks at most, the last one holds the remainder.
    localparam int ALU_WIDTH   = (WIDTH + LATENCY - 1) / LATENCY;
    localparam int CHUNK_COUNT = (WIDTH + ALU_WIDTH - 1) / ALU_WIDTH;
    // Pipeline word: {overflow, pending carries, partial value}.
    localparam int STAGE_WIDTH = 1 + CHUNK_COUNT + WIDTH;

    typedef enum logic [0:0] {
        ARMING  = 1'b0,
        MEASURE = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    // ------------------------------------------------------------------------
    // Adds a one-bit increment into every chunk independently; the carry-out
    // of each chunk is returned separately instead of entering the next chunk.
    // Result packing: {chunk carry-outs, chunk sums}.
    // ------------------------------------------------------------------------
    function automatic logic [CHUNK_COUNT+WIDTH-1:0] chunk_add(
        input logic [WIDTH-1:0]       value,
        input logic [CHUNK_COUNT-1:0] carry_in
    );
        logic [WIDTH-1:0]       sum;
        logic [CHUNK_COUNT-1:0] carry_out;
        logic                   c;
        sum       = '0;
        carry_out = '0;
        c         = 1'b0;
        for (int b = 0; b < WIDTH; b++) begin
            if ((b % ALU_WIDTH) == 0) begin
                c = carry_in[b / ALU_WIDTH];
            end
            sum[b] = value[b] ^ c;
            c      = c & value[b];
            if (((b % ALU_WIDTH) == (ALU_WIDTH - 1)) || (b == WIDTH - 1)) begin
                carry_out[b / ALU_WIDTH] = c;
            end
        end
        return {carry_out, sum};
    endfunction

    // ------------------------------------------------------------------------
    // One resolver step: every pending carry moves one chunk up. Whatever
    // leaves the top chunk becomes overflow, so the top pending bit of the
    // returned word is always zero.
    // ------------------------------------------------------------------------
    function automatic logic [STAGE_WIDTH-1:0] ripple(
        input logic [STAGE_WIDTH-1:0] word
    );
        logic [WIDTH-1:0]       value;
        logic [CHUNK_COUNT-1:0] pend;
        logic                   ovf;
        logic [CHUNK_COUNT-1:0] cin;
        logic [CHUNK_COUNT-1:0] cout;
        logic [WIDTH-1:0]       sum;
        value = word[WIDTH-1:0];
        pend  = word[WIDTH +: CHUNK_COUNT];
        ovf   = word[STAGE_WIDTH-1];
        cin   = '0;
        for (int i = 1; i < CHUNK_COUNT; i++) begin
            cin[i] = pend[i-1];
        end
        {cout, sum} = chunk_add(value, cin);
        ovf = ovf | pend[CHUNK_COUNT-1] | cout[CHUNK_COUNT-1];
        cout[CHUNK_COUNT-1] = 1'b0;
        return {ovf, cout, sum};
    endfunction

    // ------------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------------

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ARMING;
        end else begin
            state <= state_next;
        end
    end

    // Next state: the first strobe after reset only opens the first window.
    always_comb begin
        state_next = state;
        case (state)
            ARMING:  if (strobe) state_next = MEASURE;
            MEASURE: state_next = MEASURE;
            default: state_next = ARMING;
        endcase
    end

    assign armed = (state == MEASURE);

    // ------------------------------------------------------------------------
    // Chunked interval counter
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0]       cnt;
    logic [CHUNK_COUNT-1:0] carry;     // registered carry-out of each chunk
    logic                   wrap;      // sticky: top chunk has carried out
    logic [CHUNK_COUNT-1:0] cnt_cin;
    logic [CHUNK_COUNT-1:0] cnt_cout;
    logic [WIDTH-1:0]       cnt_next;

    // Chunk 0 takes the tick, every other chunk the carry of the one below.
    always_comb begin
        cnt_cin    = '0;
        cnt_cin[0] = enable;
        for (int i = 1; i < CHUNK_COUNT; i++) begin
            cnt_cin[i] = carry[i-1];
        end
    end

    assign {cnt_cout, cnt_next} = chunk_add(cnt, cnt_cin);

    // Counter state: held cleared while arming and restarted on every strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            carry <= '0;
            wrap  <= 1'b0;
        end else if ((state != MEASURE) || strobe) begin
            cnt   <= '0;
            carry <= '0;
            wrap  <= 1'b0;
        end else begin
            cnt   <= cnt_next;
            carry <= cnt_cout;
            wrap  <= wrap | carry[CHUNK_COUNT-1];
        end
    end

    // ------------------------------------------------------------------------
    // Capture: snapshot of the counter including this cycle's tick. Carries
    // leaving the top chunk (now, last cycle, or earlier) go straight into
    // the overflow bit; the remaining carries are resolved downstream.
    // ------------------------------------------------------------------------
    logic [STAGE_WIDTH-1:0] cap_word;
    logic                   cap_vld;
    logic [CHUNK_COUNT-1:0] cap_pend;
    logic                   cap_ovf;

    // Pack the capture word.
    always_comb begin
        cap_pend                = cnt_cout;
        cap_pend[CHUNK_COUNT-1] = 1'b0;
        cap_ovf                 = wrap | carry[CHUNK_COUNT-1] | cnt_cout[CHUNK_COUNT-1];
        cap_word                = {cap_ovf, cap_pend, cnt_next};
    end

    assign cap_vld = (state == MEASURE) && strobe;

    // ------------------------------------------------------------------------
    // Resolver pipeline: stage 0 holds the raw capture, each further register
    // transfer (including the one into the output register) ripples once.
    // ------------------------------------------------------------------------
    logic [STAGE_WIDTH-1:0] last_word;
    logic                   last_vld;

    generate
        if (LATENCY > 1) begin : g_pipe
            logic [STAGE_WIDTH-1:0] stage_word [LATENCY-1];
            logic [LATENCY-2:0]     stage_vld;

            // Shift captures through the resolver, one ripple per stage.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int k = 0; k < LATENCY - 1; k++) begin
                        stage_word[k] <= '0;
                    end
                    stage_vld <= '0;
                end else begin
                    stage_word[0] <= cap_word;
                    stage_vld[0]  <= cap_vld;
                    for (int k = 1; k < LATENCY - 1; k++) begin
                        stage_word[k] <= ripple(stage_word[k-1]);
                        stage_vld[k]  <= stage_vld[k-1];
                    end
                end
            end

            assign last_word = stage_word[LATENCY-2];
            assign last_vld  = stage_vld[LATENCY-2];
        end else begin : g_direct
            assign last_word = cap_word;
            assign last_vld  = cap_vld;
        end
    endgenerate

    logic [STAGE_WIDTH-1:0] res_word;
    assign res_word = ripple(last_word);

    // ------------------------------------------------------------------------
    // Output register with overrun detection
    // ------------------------------------------------------------------------

    // Load a resolved result when the slot is free or being emptied; otherwise
    // drop it and flag overrun for one cycle. Any carry still pending after
    // the last ripple is counted as overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            measure_valid    <= 1'b0;
            measure_value    <= '0;
            measure_overflow <= 1'b0;
            overrun          <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (last_vld) begin
                if (!measure_valid || measure_ready) begin
                    measure_valid    <= 1'b1;
                    measure_value    <= res_word[WIDTH-1:0];
                    measure_overflow <= res_word[STAGE_WIDTH-1] |
                                        (|res_word[WIDTH +: CHUNK_COUNT]);
                end else begin
                    overrun <= 1'b1;
                end
            end else if (measure_valid && measure_ready) begin
                measure_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_strobe_interval_meter.sv
`default_nettype none
// ============================================================================
// Module   : tb_strobe_interval_meter
// Brief    : Self-checking bench for strobe_interval_meter (WIDTH=8,
//            LATENCY=3) with a tick-counting reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_strobe_interval_meter;

    localparam int W = 8;
    localparam int L = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         enable = 1'b0;
    logic         strobe = 1'b0;
    logic         ready = 1'b0;
    logic         d_armed;
    logic [W-1:0] d_value;
    logic         d_ovf;
    logic         d_valid;
    logic         d_overrun;

    int n_checks = 0;
    int n_fail   = 0;

    strobe_interval_meter #(.WIDTH(W), .LATENCY(L)) dut (
        .clk              (clk),
        .rst              (rst),
        .enable           (enable),
        .strobe           (strobe),
        .armed            (d_armed),
        .measure_value    (d_value),
        .measure_overflow (d_ovf),
        .measure_valid    (d_valid),
        .measure_ready    (ready),
        .overrun          (d_overrun)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Reference model: ticks are counted as a plain integer per window; each
    // finished window becomes a result due L-1 edges after its strobe edge.
    // ------------------------------------------------------------------------
    typedef struct {
        longint due;
        longint ticks;
    } res_t;

    res_t         q[$];
    longint       edge_n  = 0;
    longint       m_cnt   = 0;
    logic         m_armed = 1'b0;
    logic         m_valid = 1'b0;
    logic [W-1:0] m_value = '0;
    logic         m_ovf   = 1'b0;
    logic         m_ovr   = 1'b0;

    // Model update on every rising edge.
    always @(posedge clk) begin
        res_t r;
        logic accept;
        if (!rst) begin
            q.delete();
            m_cnt   = 0;
            m_armed = 1'b0;
            m_valid = 1'b0;
            m_value = '0;
            m_ovf   = 1'b0;
            m_ovr   = 1'b0;
        end else begin
            accept = m_valid && ready;
            if (m_armed) begin
                m_cnt = m_cnt + (enable ? 1 : 0);
                if (strobe) begin
                    r.due   = edge_n + L - 1;
                    r.ticks = m_cnt;
                    q.push_back(r);
                    m_cnt = 0;
                end
            end else if (strobe) begin
                m_armed = 1'b1;
                m_cnt   = 0;
            end
            m_ovr = 1'b0;
            if (q.size() > 0 && q[0].due == edge_n) begin
                r = q.pop_front();
                if (!m_valid || accept) begin
                    m_valid = 1'b1;
                    m_value = W'(r.ticks % (longint'(1) << W));
                    m_ovf   = (r.ticks >= (longint'(1) << W));
                end else begin
                    m_ovr = 1'b1;
                end
            end else if (accept) begin
                m_valid = 1'b0;
            end
        end
        edge_n = edge_n + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Compare DUT against the model every cycle, away from the rising edge.
    always @(negedge clk) begin
        check("armed", 64'(d_armed), 64'(m_armed));
        check("valid", 64'(d_valid), 64'(m_valid));
        check("overrun", 64'(d_overrun), 64'(m_ovr));
        if (m_valid) begin
            check("value", 64'(d_value), 64'(m_value));
            check("overflow", 64'(d_ovf), 64'(m_ovf));
        end
    end

    // Hand-computed expectation applied to both DUT and model.
    task automatic lit(input string name, input logic v, input logic [W-1:0] val, input logic o);
        check({name, "_dut_valid"}, 64'(d_valid), 64'(v));
        check({name, "_mdl_valid"}, 64'(m_valid), 64'(v));
        if (v) begin
            check({name, "_dut_value"}, 64'(d_value), 64'(val));
            check({name, "_mdl_value"}, 64'(m_value), 64'(val));
            check({name, "_dut_ovf"}, 64'(d_ovf), 64'(o));
            check({name, "_mdl_ovf"}, 64'(m_ovf), 64'(o));
        end
    endtask

    task automatic step(input logic en, input logic stb, input logic rdy);
        rst    = 1'b1;
        enable = en;
        strobe = stb;
        ready  = rdy;
        @(negedge clk);
        #1;
    endtask

    task automatic rst_step();
        rst    = 1'b0;
        enable = 1'b0;
        strobe = 1'b0;
        @(negedge clk);
        #1;
    endtask

    // Stimulus: directed scenarios with literal checks, then random traffic.
    initial begin
        int ovr_seen;
        @(negedge clk);
        #1;
        check("reset_armed", 64'(d_armed), 64'd0);
        check("reset_valid", 64'(d_valid), 64'd0);
        check("reset_value", 64'(d_value), 64'd0);
        check("reset_ovf", 64'(d_ovf), 64'd0);
        check("reset_overrun", 64'(d_overrun), 64'd0);

        step(0, 0, 1);
        check("idle_armed", 64'(d_armed), 64'd0);
        step(1, 1, 1);
        check("arm_armed", 64'(d_armed), 64'd1);
        lit("arm", 1'b0, '0, 1'b0);

        // Five ticks, strobe cycle included.
        for (int i = 0; i < 4; i++) step(1, 0, 1);
        step(1, 1, 1);
        step(0, 0, 1);
        lit("five_early", 1'b0, '0, 1'b0);
        step(0, 0, 1);
        lit("five", 1'b1, 8'd5, 1'b0);

        // 260 ticks wrap an 8-bit counter: 4 with overflow, then 5 clean.
        for (int i = 0; i < 259; i++) step(1, 0, 1);
        step(1, 1, 1);
        step(1, 0, 1);
        step(1, 0, 1);
        lit("wrap", 1'b1, 8'd4, 1'b1);
        step(1, 0, 1);
        step(1, 0, 1);
        step(1, 1, 1);
        step(0, 0, 1);
        step(0, 0, 1);
        lit("after_wrap", 1'b1, 8'd5, 1'b0);

        // Back-to-back strobes with enable high on both.
        step(1, 1, 1);
        step(1, 1, 1);
        step(0, 0, 1);
        lit("b2b_first", 1'b1, 8'd1, 1'b0);
        step(0, 0, 1);
        lit("b2b_second", 1'b1, 8'd1, 1'b0);
        step(0, 0, 1);
        lit("b2b_drain", 1'b0, '0, 1'b0);

        // Ready held low across three strobes: two overruns, first kept.
        ovr_seen = 0;
        step(1, 1, 0);
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 9; i++) begin
                step(1, 0, 0);
                if (d_overrun) ovr_seen++;
            end
            step(1, 1, 0);
            if (d_overrun) ovr_seen++;
        end
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0);
            if (d_overrun) ovr_seen++;
        end
        check("overrun_pulses", 64'(ovr_seen), 64'd2);
        lit("held", 1'b1, 8'd1, 1'b0);
        step(0, 0, 1);
        lit("released", 1'b0, '0, 1'b0);

        // Reset while a result is in flight.
        step(1, 1, 1);
        step(0, 0, 1);
        rst = 1'b0;
        #1;
        check("midrst_armed", 64'(d_armed), 64'd0);
        check("midrst_valid", 64'(d_valid), 64'd0);
        check("midrst_value", 64'(d_value), 64'd0);
        check("midrst_ovf", 64'(d_ovf), 64'd0);
        check("midrst_overrun", 64'(d_overrun), 64'd0);
        @(negedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 1);
            check("postrst_valid", 64'(d_valid), 64'd0);
            check("postrst_armed", 64'(d_armed), 64'd0);
        end
        step(1, 1, 1);
        check("rearm_armed", 64'(d_armed), 64'd1);

        // Random traffic in segments of differing strobe density and ready.
        for (int seg = 0; seg < 20; seg++) begin
            int mode;
            int stb_thr;
            int rdy_thr;
            mode = int'($urandom_range(0, 2));
            stb_thr = (mode == 0) ? 300 : ((mode == 1) ? 40 : 3);
            rdy_thr = (mode == 0) ? 100 : ((mode == 1) ? 70 : 15);
            for (int c = 0; c < 200; c++) begin
                if ($urandom_range(0, 1499) == 0) begin
                    rst_step();
                    rst_step();
                end else begin
                    step($urandom_range(0, 99) < 75,
                         $urandom_range(0, 999) < stb_thr,
                         $urandom_range(0, 99) < rdy_thr);
                end
            end
        end

        for (int i = 0; i < 8; i++) step(0, 0, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/strobe_interval_meter.md
# strobe_interval_meter

Measures the number of `enable` ticks between consecutive `strobe` pulses and presents each measured interval on a valid/ready output. It is the receive-side counterpart of `counter_with_strobe`: fed with that block's `enable`/`strobe`, it reports back the `reset_value` that produced the strobe train. The counter is split into carry-pipelined chunks, using the same LATENCY-controlled chunking as the strobe generator, so wide counters close timing at speed.

## Interface
- `WIDTH`, 32, interval counter and result width in bits.
- `LATENCY`, 1, carry-pipeline depth, legal range 1..WIDTH. `ALU_WIDTH` = ceil(WIDTH/LATENCY). `CHUNK_COUNT` = ceil(WIDTH/ALU_WIDTH). The last chunk holds the remaining bits.
- `clk`  input  1  sole clock; all logic on the rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `enable`  input  1  tick qualifier; one count per cycle with `enable`=1.
- `strobe`  input  1  interval boundary event; single-cycle pulse, may be back-to-back.
- `armed`  output  1  high once the first strobe after reset has been seen.
- `measure_value`  output  WIDTH  measured tick count, modulo 2^WIDTH.
- `measure_overflow`  output  1  interval exceeded 2^WIDTH-1 ticks.
- `measure_valid`  output  1  result available.
- `measure_ready`  input  1  consumer accepts result when high with `measure_valid`.
- `overrun`  output  1  one-cycle pulse: a resolved result was dropped.

## Operation
- States: ARMING (reset state) and MEASURE. `armed` = (state == MEASURE).
  - ARMING + `strobe`: go to MEASURE and clear the counter. No result is produced.
- In MEASURE, chunk 0 adds `enable` each cycle. Chunk i>0 adds the registered carry-out of chunk i-1. Carry-out of the last chunk sets the sticky `wrap` flag.
- Interval definition: the count of cycles with `enable`=1 in the window (previous strobe cycle, current strobe cycle]. That window includes the current strobe cycle and excludes the previous one.
- Capture on `strobe` in MEASURE:
  - The capture stage loads the counter's next-state chunks, the pending carry bits and `wrap` (this cycle's `enable` included).
  - In the same edge, the counter, carries and `wrap` clear to 0.
- Resolver: a pipeline of LATENCY-1 stages.
  - Each stage ripples the pending carries one chunk further.
  - The final carry-out ORs into the overflow bit.
  - Each stage holds one capture, so back-to-back strobes are legal.
- Output register:
  - Loads on resolver exit when empty, or when `measure_valid` && `measure_ready` in the same cycle.
  - If full and not being accepted, the new result is discarded. `overrun` pulses and the old result is kept.
- Reset mid-operation: counter, pipeline, output register and state clear asynchronously. In-flight results are lost.

## Timing
- Reset values: `armed`=0, `measure_valid`=0, `measure_value`=0, `measure_overflow`=0, `overrun`=0.
- Strobe at cycle t (MEASURE) -> `measure_valid` high at t+LATENCY (LATENCY=1: the next cycle), provided the output register is free.
- `measure_valid` stays high until the handshake cycle. It drops the following cycle unless a new result loads in that same cycle.
- `overrun` is registered and asserts in the cycle the dropped result would have loaded.
- Zero-enable interval yields `measure_value`=0, which is delivered normally.
- Wrap: the counter wraps to 0, `measure_value` = ticks mod 2^WIDTH, `measure_overflow`=1.
- `strobe` while `enable`=0 at the boundary: the tick window is unchanged and no tick is lost.

## Test plan
- WIDTH=32, LATENCY=1, enable constant 1, strobes every 7 cycles, ready=1 -> ARMING on first strobe; then each result is 7, valid 1 cycle after each strobe.
- WIDTH=16, LATENCY=4, drive from `counter_with_strobe` (reset_value=300) with enable toggling 1/0 -> every result = 300, valid 4 cycles after each strobe.
- WIDTH=8, LATENCY=2, 260 enables between strobes -> value=4, overflow=1; next interval of 5 ticks -> value=5, overflow=0.
- Strobe on two consecutive cycles with enable=1 on both, LATENCY=3 -> results 1 and 1 (after the preceding result), on consecutive valid cycles.
- Hold ready=0, three strobes 10 ticks apart -> first result held, overrun pulses twice; ready=1 releases the first result only.
- Assert rst=0 two cycles after a strobe with LATENCY=4 -> all outputs 0 immediately, no result emerges, `armed`=0 until the next strobe.
